rr_arb6: RTL and testbench
==========================

RR_ARB6 -- requirements
Module: rr_arb6

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 8, the maximum transfers per grant before forced release (legal range 1..15).
REQ-002 SHALL have parameter PARK_SEL, default 3'b000, the sel value driven while no grant is held.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 6, request per requester (bit i = requester i).
REQ-006 SHALL have port last, input, 6, marks the final beat of requester i's burst.
REQ-007 SHALL have port ready, input, 1, downstream accepts the beat selected by sel.
REQ-008 SHALL have port sel, output, 3, registered select for the 6:1 datapath mux (0..5 only).
REQ-009 SHALL have port gnt, output, 6, registered one-hot grant, all-zero when idle.
REQ-010 SHALL have port valid, output, 1, beat presented: (state==GRANT) & req[sel].
REQ-011 SHALL have port done, output, 1, one-cycle pulse on the cycle the grant is released.

Function
REQ-012 SHALL implement states IDLE and GRANT; gnt is one-hot exactly when in GRANT.
REQ-013 SHALL hold a 3-bit priority pointer ptr (0..5); the search order is ptr, ptr+1, ..., wrapping 5->0.
REQ-014 In IDLE with req!=0, SHALL select the first asserted req in the search order and enter GRANT next edge: sel and gnt update, one cycle of latency from req to gnt.
REQ-015 In IDLE with req==0, SHALL stay IDLE with sel=PARK_SEL and gnt=0.
REQ-016 SHALL define transfer = valid & ready; each transfer increments a 4-bit beat counter.
REQ-017 Release SHALL occur on a transfer with last[sel]=1, or on the transfer that makes the beat count equal MAX_BEATS, or on any GRANT cycle with req[sel]=0 (abort, no transfer).
REQ-018 On release, SHALL pulse done, clear the beat counter, and set ptr = sel+1 mod 6.
REQ-019 On release, SHALL arbitrate in the same cycle using the updated pointer over the current req: if any are asserted, move directly to GRANT of the winner on the next edge (no idle bubble); otherwise go to IDLE.
REQ-020 The released requester SHALL win back-to-back only if no other req bit is asserted.
REQ-021 While in GRANT without release, sel, gnt and ptr SHALL hold; changes on other req bits SHALL be ignored.
REQ-022 When ready=0 in GRANT, SHALL hold all state; the beat count does not advance.
REQ-023 last bits of non-granted requesters SHALL be ignored.
REQ-024 sel SHALL never take values 6 or 7.

Reset
REQ-025 When reset asserts, SHALL immediately force state=IDLE, sel=PARK_SEL, gnt=0, done=0, ptr=0 and beat count=0, regardless of the clock.
REQ-026 A burst in progress when reset asserts SHALL be abandoned; no done pulse.
REQ-027 After reset deasserts, the first grant SHALL use ptr=0 priority.

Verification
REQ-028 Reset, then req=6'b100001, ready=1, last=6'b111111 -> gnt=000001 (sel=0) with done; next grant 100000 (sel=5); next 000001; there are no idle cycles between grants.
REQ-029 req=6'b000100 held, last=0, ready=1, MAX_BEATS=8 -> exactly 8 transfers, done on the 8th, then 1-cycle gap is absent: re-grant sel=2 immediately since it is the sole requester.
REQ-030 Granted sel=3, ready=0 for 5 cycles -> sel, gnt and beat count are unchanged; then ready=1 with last[3]=1 -> one transfer and done.
REQ-031 Granted sel=1 mid-burst, req[1] drops -> valid=0 and done the same cycle; ptr=2; pending req[4] is granted the next edge.
REQ-032 reset pulse asserted between clock edges during a burst at sel=4 -> gnt=0 and sel=PARK_SEL at once; after release, req=6'b111111 grants sel=0.
REQ-033 Random req, last and ready for 10k cycles -> gnt is always one-hot or zero, sel<=5, and no requester waits more than 5 grants.

Source files
------------

// File: rtl/rr_arb6.sv
// rr_arb6: six-way round-robin burst arbiter.
// Grants one requester per burst and drives a registered mux select.
module rr_arb6 #(
  parameter int unsigned MAX_BEATS = 8,
  parameter logic [2:0]  PARK_SEL  = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] req,
  input  logic [5:0] last,
  input  logic       ready,
  output logic [2:0] sel,
  output logic [5:0] gnt,
  output logic       valid,
  output logic       done
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BEATS);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [5:0] gnt_q, gnt_d;
  logic [3:0] beat_q, beat_d;

  logic       xfer;
  logic       rel;
  logic       last_beat;
  logic [2:0] arb_ptr;
  logic [3:0] win;

  function automatic logic [2:0] inc6(input logic [2:0] v);
    return (v == 3'd5) ? 3'd0 : v + 3'd1;
  endfunction

  // {found, index} of the first set req bit searching from p
  function automatic logic [3:0] pick(
    input logic [5:0] r,
    input logic [2:0] p
  );
    logic [2:0] idx;
    logic [3:0] res;
    res = 4'b0;
    idx = p;
    for (int i = 0; i < 6; i++) begin
      if (!res[3] && r[idx]) res = {1'b1, idx};
      idx = inc6(idx);
    end
    return res;
  endfunction

  // Next-state, release detection and same-cycle re-arbitration
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    done      = 1'b0;
    valid     = (state_q == GRANT) & req[sel_q];
    xfer      = valid & ready;
    last_beat = (beat_q + 4'd1) == MAX_B;
    rel       = (state_q == GRANT) &
                (~req[sel_q] | (xfer & (last[sel_q] | last_beat)));
    arb_ptr   = rel ? inc6(sel_q) : ptr_q;
    win       = pick(req, arb_ptr);
    unique case (state_q)
      IDLE: begin
        if (win[3]) begin
          state_d = GRANT;
          sel_d   = win[2:0];
          gnt_d   = 6'd1 << win[2:0];
        end else begin
          sel_d = PARK_SEL;
          gnt_d = 6'd0;
        end
      end
      GRANT: begin
        if (rel) begin
          done   = 1'b1;
          ptr_d  = arb_ptr;
          beat_d = 4'd0;
          if (win[3]) begin
            state_d = GRANT;
            sel_d   = win[2:0];
            gnt_d   = 6'd1 << win[2:0];
          end else begin
            state_d = IDLE;
            sel_d   = PARK_SEL;
            gnt_d   = 6'd0;
          end
        end else if (xfer) begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any burst in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= PARK_SEL;
      gnt_q   <= 6'd0;
      ptr_q   <= 3'd0;
      beat_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  assign sel = sel_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_rr_arb6.sv
// tb_rr_arb6: directed and random checks of rr_arb6
// against a behavioural round-robin reference.
module tb_rr_arb6;

  localparam int         MB = 8;
  localparam logic [2:0] PS = 3'b101;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] req, last;
  logic       ready;
  logic [2:0] sel;
  logic [5:0] gnt;
  logic       valid, done;

  int checks   = 0;
  int failures = 0;

  bit m_gr;
  int m_cur, m_ptr, m_beats;

  logic [5:0] p_req, p_gnt;
  logic       p_done;
  int         wt[6];
  int         max_wait = 0;

  rr_arb6 #(.MAX_BEATS(MB), .PARK_SEL(PS)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last),
    .ready(ready), .sel(sel), .gnt(gnt),
    .valid(valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int first_from(input logic [5:0] r, input int p);
    for (int k = 0; k < 6; k++)
      if (r[(p + k) % 6]) return (p + k) % 6;
    return -1;
  endfunction

  task automatic model_reset();
    m_gr = 0; m_cur = 0; m_ptr = 0; m_beats = 0;
    p_req = '0; p_gnt = '0; p_done = 1'b0;
    for (int i = 0; i < 6; i++) wt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; last = '0; ready = 1'b0;
    #1;
    chk("rst_sel", 8'(sel), 8'(PS));
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_done", 8'(done), 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic [5:0] r, input logic [5:0] l,
                      input logic rd);
    logic [2:0] e_sel;
    logic [5:0] e_gnt;
    logic       e_valid, e_xfer, e_rel;
    int         w;
    @(negedge clk);
    req = r; last = l; ready = rd;
    #1;
    e_sel   = m_gr ? 3'(m_cur) : PS;
    e_gnt   = m_gr ? 6'(1 << m_cur) : 6'd0;
    e_valid = m_gr && r[m_cur];
    e_xfer  = e_valid && rd;
    e_rel   = m_gr && (!r[m_cur] ||
              (e_xfer && (l[m_cur] || m_beats + 1 == MB)));
    chk("sel", 8'(sel), 8'(e_sel));
    chk("gnt", 8'(gnt), 8'(e_gnt));
    chk("valid", 8'(valid), 8'(e_valid));
    chk("done", 8'(done), 8'(e_rel));
    chk("onehot0", 8'($onehot0(gnt)), 8'h01);
    chk("sel_range", 8'(sel <= 3'd5), 8'h01);
    if (gnt != 0 && (p_gnt == 0 || p_done)) begin
      for (int i = 0; i < 6; i++) begin
        if (i == int'(sel) || !p_req[i]) wt[i] = 0;
        else wt[i]++;
        if (wt[i] > max_wait) max_wait = wt[i];
      end
    end
    for (int i = 0; i < 6; i++)
      if (!r[i]) wt[i] = 0;
    p_req = r; p_gnt = gnt; p_done = done;
    if (!m_gr) begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin m_gr = 1; m_cur = w; end
    end else if (e_rel) begin
      m_ptr   = (m_cur + 1) % 6;
      m_beats = 0;
      w       = first_from(r, m_ptr);
      m_gr    = (w >= 0);
      if (w >= 0) m_cur = w;
    end else if (e_xfer) begin
      m_beats++;
    end
    @(posedge clk);
  endtask

  initial begin
    logic [5:0] r;
    reset = 1'b1; req = '0; last = '0; ready = 1'b0;
    model_reset();
    do_reset();

    // alternating pair, single-beat bursts
    for (int k = 0; k < 5; k++) step(6'b100001, 6'b111111, 1'b1);

    // sole requester hits the beat limit and is re-granted
    do_reset();
    for (int k = 0; k < 12; k++) step(6'b000100, 6'b000000, 1'b1);

    // stalled grant holds, then finishes on last
    do_reset();
    step(6'b001000, 6'b000000, 1'b1);
    for (int k = 0; k < 5; k++) step(6'b001000, 6'b000000, 1'b0);
    step(6'b001000, 6'b001000, 1'b1);
    step(6'b000000, 6'b000000, 1'b1);

    // abort moves pointer past the aborting requester
    do_reset();
    step(6'b000010, 6'b000000, 1'b1);
    step(6'b010010, 6'b000000, 1'b1);
    step(6'b010001, 6'b000000, 1'b1);
    step(6'b010001, 6'b000000, 1'b1);
    chk("abort_winner", 8'(sel), 8'd4);

    // asynchronous reset mid-burst
    do_reset();
    step(6'b010000, 6'b000000, 1'b1);
    step(6'b010000, 6'b000000, 1'b1);
    #2;
    reset = 1'b1; req = '0;
    #1;
    chk("async_gnt", 8'(gnt), 8'h00);
    chk("async_sel", 8'(sel), 8'(PS));
    chk("async_done", 8'(done), 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(6'b111111, 6'b000000, 1'b1);
    step(6'b111111, 6'b000000, 1'b1);
    chk("post_rst_sel", 8'(sel), 8'd0);

    // random traffic
    do_reset();
    r = 6'($urandom);
    for (int k = 0; k < 10000; k++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      step(r, 6'($urandom) & 6'($urandom),
           1'($urandom_range(3) != 0));
    end
    chk("fair_wait", 8'(max_wait <= 5), 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
